n_bit_adder: RTL and testbench

N_BIT_ADDER -- requirements
Module: n_bit_adder

---
 rtl/n_bit_adder.sv | 49 ++++
 tb/tb_n_bit_adder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/n_bit_adder.sv
// Registered N-bit ripple-carry adder with carry-out and signed overflow.
// Ports: clk, reset (sync, active-high), in_valid, a, b, cin -> s, carryOut, overflow, out_valid.
module n_bit_adder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         carryOut,
  output logic         overflow,
  output logic         out_valid
);

  // c[i] is the carry into bit i; c[N] is the carry out of the MSB.
  logic [N:0]   c;
  logic [N-1:0] sum;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  // Result registers only load on in_valid, so X operands while idle
  // never reach the held outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s        <= sum;
        carryOut <= c[N];
        overflow <= c[N] ^ c[N-1];
      end
    end
  end

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder at N=32, N=8 and N=1.
// Directed corner cases, then randomized traffic against a behavioural model.
module tb_n_bit_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;

  logic [31:0] s32;
  logic [7:0]  s8;
  logic [0:0]  s1;
  logic        co32, co8, co1;
  logic        ov32, ov8, ov1;
  logic        v32, v8, v1;

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: index 0 -> N=32, 1 -> N=8, 2 -> N=1.
  int          wid [3] = '{32, 8, 1};
  logic [31:0] e_s [3];
  logic        e_co [3];
  logic        e_ov [3];
  logic        e_v [3];

  always #5 clk = ~clk;

  n_bit_adder #(.N(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin),
    .s(s32), .carryOut(co32), .overflow(ov32), .out_valid(v32)
  );

  n_bit_adder #(.N(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .s(s8), .carryOut(co8), .overflow(ov8), .out_valid(v8)
  );

  n_bit_adder #(.N(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .s(s1), .carryOut(co1), .overflow(ov1), .out_valid(v1)
  );

  // Plain arithmetic reference: full-width integer sum, and signed
  // overflow as "same-sign operands give a differently-signed result".
  function automatic void model(input int w, input logic [31:0] av,
                                input logic [31:0] bv, input logic ci,
                                output logic [31:0] so, output logic co,
                                output logic ov);
    longint unsigned m, x, y, t;
    bit sa, sb, ss;
    m  = (64'd1 << w) - 64'd1;
    x  = longint'(av) & m;
    y  = longint'(bv) & m;
    t  = x + y + longint'(ci);
    so = 32'(t & m);
    co = 1'((t >> w) & 64'd1);
    sa = 1'((x >> (w - 1)) & 64'd1);
    sb = 1'((y >> (w - 1)) & 64'd1);
    ss = 1'((t >> (w - 1)) & 64'd1);
    ov = (sa == sb) && (ss != sa);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, " n32.s"},  s32, e_s[0]);
    chk({tag, " n32.co"}, 32'(co32), 32'(e_co[0]));
    chk({tag, " n32.ov"}, 32'(ov32), 32'(e_ov[0]));
    chk({tag, " n32.v"},  32'(v32), 32'(e_v[0]));
    chk({tag, " n8.s"},   32'(s8), e_s[1]);
    chk({tag, " n8.co"},  32'(co8), 32'(e_co[1]));
    chk({tag, " n8.ov"},  32'(ov8), 32'(e_ov[1]));
    chk({tag, " n8.v"},   32'(v8), 32'(e_v[1]));
    chk({tag, " n1.s"},   32'(s1), e_s[2]);
    chk({tag, " n1.co"},  32'(co1), 32'(e_co[2]));
    chk({tag, " n1.ov"},  32'(ov1), 32'(e_ov[2]));
    chk({tag, " n1.v"},   32'(v1), 32'(e_v[2]));
  endtask

  // Drive one cycle at the falling edge, let the rising edge capture,
  // advance the model and check 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [31:0] av, input logic [31:0] bv,
                      input logic ci);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = ci;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        e_s[k]  = '0;
        e_co[k] = 1'b0;
        e_ov[k] = 1'b0;
        e_v[k]  = 1'b0;
      end else begin
        e_v[k] = v;
        if (v) model(wid[k], av, bv, ci, e_s[k], e_co[k], e_ov[k]);
      end
    end
    compare(tag);
  endtask

  initial begin
    logic        rr, vv, cc;
    logic [31:0] ra, rb;
    reset    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset wins over a capture presented in the same cycle.
    step("rst_cap", 1'b1, 1'b1, 32'd5, 32'd6, 1'b1);
    step("rst2",    1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    step("3p4",     1'b0, 1'b1, 32'd3, 32'd4, 1'b0);
    step("wrap",    1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step("ovf_pos", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    step("ovf_neg", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("cin_wrap",1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Idle with undriven operands: outputs must hold.
    step("hold1",   1'b0, 1'b0, 'x, 'x, 1'bx);
    step("hold2",   1'b0, 1'b0, 'x, 'x, 1'bx);
    step("hold3",   1'b0, 1'b0, 'x, 'x, 1'bx);

    // Stream with reset in the middle.
    step("st_7",    1'b0, 1'b1, 32'd3,  32'd4,  1'b0);
    step("st_rst",  1'b1, 1'b1, 32'd10, 32'd20, 1'b0);
    step("st_2",    1'b0, 1'b1, 32'd1,  32'd1,  1'b0);
    step("sub_ovf", 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      vv = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = $urandom;
      cc = 1'($urandom_range(0, 1));
      step("rand", rr, vv, ra, rb, cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
